// File: rtl/anton_neopixel_bus_arbiter_if.sv
// Shared bus bundle for the neopixel bus arbiter: both requester channels
// plus the byte-wide register bus toward the neopixel module.
interface anton_neopixel_bus_arbiter_if;
  logic        m0Valid;
  logic        m0Write;
  logic [17:0] m0Addr;
  logic [7:0]  m0Data;
  logic        m0Lock;
  logic        m0Ready;
  logic        m0Grant;
  logic        m0RspValid;
  logic [7:0]  m0RspData;

  logic        m1Valid;
  logic        m1Write;
  logic [17:0] m1Addr;
  logic [7:0]  m1Data;
  logic        m1Lock;
  logic        m1Ready;
  logic        m1Grant;
  logic        m1RspValid;
  logic [7:0]  m1RspData;

  logic [17:0] busAddr;
  logic [7:0]  busDataIn;
  logic        busWrite;
  logic        busRead;
  logic [7:0]  busDataOut;

  // Arbiter side.
  modport slave (
    input  m0Valid, m0Write, m0Addr, m0Data, m0Lock,
    output m0Ready, m0Grant, m0RspValid, m0RspData,
    input  m1Valid, m1Write, m1Addr, m1Data, m1Lock,
    output m1Ready, m1Grant, m1RspValid, m1RspData,
    output busAddr, busDataIn, busWrite, busRead,
    input  busDataOut
  );

  // Requester / neopixel-module side.
  modport master (
    output m0Valid, m0Write, m0Addr, m0Data, m0Lock,
    input  m0Ready, m0Grant, m0RspValid, m0RspData,
    output m1Valid, m1Write, m1Addr, m1Data, m1Lock,
    input  m1Ready, m1Grant, m1RspValid, m1RspData,
    input  busAddr, busDataIn, busWrite, busRead,
    output busDataOut
  );
endinterface

// File: rtl/anton_neopixel_bus_arbiter.sv
// Two-requester round-robin arbiter for the neopixel register bus.
// Requester 0 is the CPU bridge, requester 1 the frame DMA. Supports locked
// bursts capped at MAX_BURST while the other side waits, and one outstanding
// read whose response goes back to the owner only.
module anton_neopixel_bus_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 16
) (
  input  logic busClk,
  input  logic busReset,
  anton_neopixel_bus_arbiter_if.slave arb
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    OWN0    = 3'd1,
    OWN1    = 3'd2,
    RDWAIT0 = 3'd3,
    RDWAIT1 = 3'd4
  } stateT;

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);
  localparam logic [2:0] READ_LAT_C  = 3'(READ_LATENCY);

  stateT       stateR, stateNextS;
  logic        lastGrantR;
  logic [7:0]  burstCntR;
  logic        lockR;
  logic [2:0]  waitCntR;
  logic [17:0] busAddrR;
  logic [7:0]  busDataInR;
  logic        busWriteR, busReadR;
  logic        rspValid0R, rspValid1R;
  logic [7:0]  rspData0R, rspData1R;

  logic        ownerS, ownValidS, ownWriteS, ownLockS, otherValidS;
  logic [17:0] ownAddrS;
  logic [7:0]  ownDataS, burstIncS;
  logic        acceptS, inRdWaitS, win0S, win1S;
  logic        capNowS, capAcceptS, captureS, rspDoneS;

  // Owner-side request mux, arbitration decision and burst-cap evaluation.
  always_comb begin
    ownerS = (stateR == OWN1) || (stateR == RDWAIT1);
    if (ownerS) begin
      ownValidS   = arb.m1Valid;
      ownWriteS   = arb.m1Write;
      ownAddrS    = arb.m1Addr;
      ownDataS    = arb.m1Data;
      ownLockS    = arb.m1Lock;
      otherValidS = arb.m0Valid;
    end else begin
      ownValidS   = arb.m0Valid;
      ownWriteS   = arb.m0Write;
      ownAddrS    = arb.m0Addr;
      ownDataS    = arb.m0Data;
      ownLockS    = arb.m0Lock;
      otherValidS = arb.m1Valid;
    end
    acceptS   = ((stateR == OWN0) || (stateR == OWN1)) && ownValidS;
    inRdWaitS = (stateR == RDWAIT0) || (stateR == RDWAIT1);
    // On a tie the requester that did not win last time gets the bus.
    win0S = arb.m0Valid && (!arb.m1Valid || lastGrantR);
    win1S = arb.m1Valid && (!arb.m0Valid || !lastGrantR);
    if (burstCntR == 8'hFF) begin
      burstIncS = burstCntR;
    end else begin
      burstIncS = burstCntR + 8'd1;
    end
    capNowS    = (burstCntR >= MAX_BURST_C) && otherValidS;
    capAcceptS = (burstIncS >= MAX_BURST_C) && otherValidS;
    captureS   = inRdWaitS && (waitCntR == READ_LAT_C);
    rspDoneS   = rspValid0R || rspValid1R;
  end

  // State register.
  always_ff @(posedge busClk) begin
    if (busReset) begin
      stateR <= IDLE;
    end else begin
      stateR <= stateNextS;
    end
  end

  // Next-state logic: grant, hold, read wait and release decisions.
  always_comb begin
    stateNextS = stateR;
    case (stateR)
      IDLE: begin
        if (win0S) begin
          stateNextS = OWN0;
        end else if (win1S) begin
          stateNextS = OWN1;
        end else begin
          stateNextS = IDLE;
        end
      end
      OWN0, OWN1: begin
        if (acceptS) begin
          if (!ownWriteS) begin
            stateNextS = ownerS ? RDWAIT1 : RDWAIT0;
          end else if (!ownLockS || capAcceptS) begin
            stateNextS = IDLE;
          end else begin
            stateNextS = stateR;
          end
        end else if (!ownLockS || capNowS) begin
          // Owner has gone quiet without lock, or the other side has waited long enough.
          stateNextS = IDLE;
        end else begin
          stateNextS = stateR;
        end
      end
      RDWAIT0, RDWAIT1: begin
        if (rspDoneS) begin
          if (!lockR || capNowS) begin
            stateNextS = IDLE;
          end else begin
            stateNextS = ownerS ? OWN1 : OWN0;
          end
        end else begin
          stateNextS = stateR;
        end
      end
      default: stateNextS = IDLE;
    endcase
  end

  // Output decode: ready/grant from state, everything else from registers.
  always_comb begin
    arb.m0Ready    = (stateR == OWN0);
    arb.m1Ready    = (stateR == OWN1);
    arb.m0Grant    = (stateR == OWN0) || (stateR == RDWAIT0);
    arb.m1Grant    = (stateR == OWN1) || (stateR == RDWAIT1);
    arb.m0RspValid = rspValid0R;
    arb.m1RspValid = rspValid1R;
    arb.m0RspData  = rspData0R;
    arb.m1RspData  = rspData1R;
    arb.busAddr    = busAddrR;
    arb.busDataIn  = busDataInR;
    arb.busWrite   = busWriteR;
    arb.busRead    = busReadR;
  end

  // Bus strobes, address/data capture, burst counting and round-robin memory.
  always_ff @(posedge busClk) begin
    if (busReset) begin
      busWriteR  <= 1'b0;
      busReadR   <= 1'b0;
      busAddrR   <= 18'd0;
      busDataInR <= 8'd0;
      lockR      <= 1'b0;
      burstCntR  <= 8'd0;
      lastGrantR <= 1'b1;
    end else begin
      busWriteR <= acceptS && ownWriteS;
      busReadR  <= acceptS && !ownWriteS;
      if (acceptS) begin
        busAddrR   <= ownAddrS;
        busDataInR <= ownDataS;
        lockR      <= ownLockS;
        burstCntR  <= burstIncS;
      end else if ((stateR == IDLE) && (win0S || win1S)) begin
        burstCntR  <= 8'd0;
        lastGrantR <= !win0S;
      end
    end
  end

  // Read latency counter and owner-only response capture.
  always_ff @(posedge busClk) begin
    if (busReset) begin
      waitCntR   <= 3'd0;
      rspValid0R <= 1'b0;
      rspValid1R <= 1'b0;
      rspData0R  <= 8'd0;
      rspData1R  <= 8'd0;
    end else begin
      if (acceptS) begin
        waitCntR <= 3'd0;
      end else if (inRdWaitS && (waitCntR != 3'd7)) begin
        waitCntR <= waitCntR + 3'd1;
      end
      rspValid0R <= captureS && !ownerS;
      rspValid1R <= captureS && ownerS;
      if (captureS && !ownerS) begin
        rspData0R <= arb.busDataOut;
      end
      if (captureS && ownerS) begin
        rspData1R <= arb.busDataOut;
      end
    end
  end

endmodule

// File: tb/tb_anton_neopixel_bus_arbiter.sv
// Directed bench for anton_neopixel_bus_arbiter (READ_LATENCY=1, MAX_BURST=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_anton_neopixel_bus_arbiter;
  logic busClk = 1'b0;
  logic busReset;
  int   compared = 0;
  int   mismatched = 0;

  anton_neopixel_bus_arbiter_if ifc();

  anton_neopixel_bus_arbiter #(.READ_LATENCY(1), .MAX_BURST(4)) dut (
    .busClk  (busClk),
    .busReset(busReset),
    .arb     (ifc)
  );

  always #5 busClk = ~busClk;

  task automatic clearInputs();
    ifc.m0Valid = 1'b0; ifc.m0Write = 1'b0; ifc.m0Addr = 18'd0; ifc.m0Data = 8'd0; ifc.m0Lock = 1'b0;
    ifc.m1Valid = 1'b0; ifc.m1Write = 1'b0; ifc.m1Addr = 18'd0; ifc.m1Data = 8'd0; ifc.m1Lock = 1'b0;
    ifc.busDataOut = 8'hEE;
  endtask

  task automatic applyReset();
    @(negedge busClk);
    busReset = 1'b1;
    clearInputs();
    @(negedge busClk);
    @(negedge busClk);
    busReset = 1'b0;
  endtask

  task automatic test_reset();
    logic [49:0] outs;
    logic [3:0]  gr;
    @(negedge busClk);
    busReset = 1'b1;
    clearInputs();
    @(negedge busClk);
    @(negedge busClk);
    outs = {ifc.m0Ready, ifc.m0Grant, ifc.m0RspValid, ifc.m0RspData,
            ifc.m1Ready, ifc.m1Grant, ifc.m1RspValid, ifc.m1RspData,
            ifc.busAddr, ifc.busDataIn, ifc.busWrite, ifc.busRead};
    compared++;
    if (outs !== 50'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    busReset = 1'b0;
    ifc.m0Valid = 1'b1; ifc.m0Write = 1'b1; ifc.m0Addr = 18'h00001; ifc.m0Data = 8'h11;
    ifc.m1Valid = 1'b1; ifc.m1Write = 1'b1; ifc.m1Addr = 18'h00002; ifc.m1Data = 8'h22;
    @(negedge busClk);
    gr = {ifc.m0Grant, ifc.m0Ready, ifc.m1Grant, ifc.m1Ready};
    compared++;
    if (gr !== 4'b1100) begin
      mismatched++;
      $display("FAIL first_tie_grant: got %b expected 1100", gr);
    end
    clearInputs();
  endtask

  task automatic test_write_stream();
    logic [27:0] got, exp;
    applyReset();
    ifc.m0Valid = 1'b1; ifc.m0Write = 1'b1; ifc.m0Addr = 18'h00010; ifc.m0Data = 8'hA0; ifc.m0Lock = 1'b1;
    @(negedge busClk);
    compared++;
    if (ifc.m0Ready !== 1'b1) begin
      mismatched++;
      $display("FAIL stream_ready: got %b expected 1", ifc.m0Ready);
    end
    for (int i = 0; i < 4; i++) begin
      ifc.m0Addr = 18'h00010 + 18'(i);
      ifc.m0Data = 8'hA0 + 8'(i);
      ifc.m0Lock = (i < 3);
      if (i == 3) begin
        ifc.m1Valid = 1'b1; ifc.m1Write = 1'b1; ifc.m1Addr = 18'h00020; ifc.m1Data = 8'h55; ifc.m1Lock = 1'b0;
      end
      @(negedge busClk);
      got = {ifc.busWrite, ifc.busRead, ifc.busAddr, ifc.busDataIn};
      exp = {1'b1, 1'b0, 18'h00010 + 18'(i), 8'hA0 + 8'(i)};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL stream_write%0d: got %h expected %h", i, got, exp);
      end
    end
    compared++;
    if ({ifc.m0Grant, ifc.m1Grant} !== 2'b00) begin
      mismatched++;
      $display("FAIL stream_idle: got grants %b expected 00", {ifc.m0Grant, ifc.m1Grant});
    end
    ifc.m0Valid = 1'b0;
    @(negedge busClk);
    compared++;
    if ({ifc.m1Grant, ifc.m0Grant, ifc.busWrite} !== 3'b100) begin
      mismatched++;
      $display("FAIL stream_handover: got %b expected 100", {ifc.m1Grant, ifc.m0Grant, ifc.busWrite});
    end
    clearInputs();
  endtask

  task automatic test_read_latency();
    applyReset();
    ifc.m1Valid = 1'b1; ifc.m1Write = 1'b0; ifc.m1Addr = 18'h3FFFF; ifc.m1Lock = 1'b0;
    @(negedge busClk);                 // granted, accepted at the next edge
    @(negedge busClk);                 // busRead cycle
    compared++;
    if ({ifc.busRead, ifc.busWrite, ifc.busAddr, ifc.m1Ready} !== {1'b1, 1'b0, 18'h3FFFF, 1'b0}) begin
      mismatched++;
      $display("FAIL read_strobe: got rd=%b wr=%b addr=%h rdy=%b expected 1 0 3ffff 0",
               ifc.busRead, ifc.busWrite, ifc.busAddr, ifc.m1Ready);
    end
    ifc.m1Valid = 1'b0;
    @(posedge busClk);
    #1 ifc.busDataOut = 8'h5C;
    @(negedge busClk);
    compared++;
    if ({ifc.m1RspValid, ifc.m0RspValid} !== 2'b00) begin
      mismatched++;
      $display("FAIL read_early_rsp: got %b expected 00", {ifc.m1RspValid, ifc.m0RspValid});
    end
    @(posedge busClk);
    #1 ifc.busDataOut = 8'hEE;
    @(negedge busClk);
    compared++;
    if ({ifc.m1RspValid, ifc.m1RspData, ifc.m0RspValid} !== {1'b1, 8'h5C, 1'b0}) begin
      mismatched++;
      $display("FAIL read_rsp: got v1=%b d1=%h v0=%b expected 1 5c 0",
               ifc.m1RspValid, ifc.m1RspData, ifc.m0RspValid);
    end
    @(negedge busClk);
    compared++;
    if ({ifc.m1RspValid, ifc.m1Grant} !== 2'b00) begin
      mismatched++;
      $display("FAIL read_release: got %b expected 00", {ifc.m1RspValid, ifc.m1Grant});
    end
    clearInputs();
  endtask

  task automatic test_fairness();
    applyReset();
    ifc.m0Valid = 1'b1; ifc.m0Write = 1'b1; ifc.m0Addr = 18'h00100; ifc.m0Data = 8'h33; ifc.m0Lock = 1'b1;
    ifc.m1Valid = 1'b1; ifc.m1Write = 1'b1; ifc.m1Addr = 18'h00200; ifc.m1Data = 8'h44; ifc.m1Lock = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge busClk);
      if (cyc >= 2 && cyc <= 5) begin
        compared++;
        if ({ifc.busWrite, ifc.busAddr} !== {1'b1, 18'h00100 + 18'(cyc - 1)}) begin
          mismatched++;
          $display("FAIL cap_strobe_c%0d: got wr=%b addr=%h expected 1 %h",
                   cyc, ifc.busWrite, ifc.busAddr, 18'h00100 + 18'(cyc - 1));
        end
      end
      if (cyc == 5) begin
        compared++;
        if ({ifc.m0Grant, ifc.m1Grant} !== 2'b00) begin
          mismatched++;
          $display("FAIL cap_release: got %b expected 00", {ifc.m0Grant, ifc.m1Grant});
        end
      end
      if (cyc == 6) begin
        compared++;
        if ({ifc.m1Grant, ifc.m0Grant, ifc.busWrite} !== 3'b100) begin
          mismatched++;
          $display("FAIL cap_handover: got %b expected 100", {ifc.m1Grant, ifc.m0Grant, ifc.busWrite});
        end
      end
      ifc.m0Addr = 18'h00100 + 18'(cyc);
    end
    clearInputs();
  endtask

  task automatic test_lock_keep();
    applyReset();
    ifc.m0Valid = 1'b1; ifc.m0Write = 1'b1; ifc.m0Addr = 18'h00300; ifc.m0Data = 8'h66; ifc.m0Lock = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge busClk);
      if (cyc >= 2) begin
        compared++;
        if ({ifc.busWrite, ifc.m0Grant, ifc.m1Grant} !== 3'b110) begin
          mismatched++;
          $display("FAIL lock_keep_c%0d: got %b expected 110", cyc, {ifc.busWrite, ifc.m0Grant, ifc.m1Grant});
        end
      end
    end
    clearInputs();
  endtask

  task automatic test_round_robin();
    logic [1:0]  expG;
    logic [17:0] expA;
    applyReset();
    ifc.m0Valid = 1'b1; ifc.m0Write = 1'b1; ifc.m0Addr = 18'h00AAA; ifc.m0Data = 8'h0A; ifc.m0Lock = 1'b0;
    ifc.m1Valid = 1'b1; ifc.m1Write = 1'b1; ifc.m1Addr = 18'h00BBB; ifc.m1Data = 8'h0B; ifc.m1Lock = 1'b0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge busClk);
      if (cyc % 2 == 0) begin
        expG = 2'b00;
      end else if (((cyc - 1) / 2) % 2 == 0) begin
        expG = 2'b10;
      end else begin
        expG = 2'b01;
      end
      compared++;
      if ({ifc.m0Grant, ifc.m1Grant} !== expG) begin
        mismatched++;
        $display("FAIL rr_grant_c%0d: got %b expected %b", cyc, {ifc.m0Grant, ifc.m1Grant}, expG);
      end
      if (cyc % 2 == 0) begin
        expA = (cyc % 4 == 2) ? 18'h00AAA : 18'h00BBB;
        compared++;
        if ({ifc.busWrite, ifc.busAddr} !== {1'b1, expA}) begin
          mismatched++;
          $display("FAIL rr_write_c%0d: got wr=%b addr=%h expected 1 %h", cyc, ifc.busWrite, ifc.busAddr, expA);
        end
      end
    end
    clearInputs();
  endtask

  task automatic test_reset_mid_read();
    applyReset();
    ifc.busDataOut = 8'h77;
    ifc.m0Valid = 1'b1; ifc.m0Write = 1'b0; ifc.m0Addr = 18'h00123; ifc.m0Lock = 1'b0;
    @(negedge busClk);
    @(negedge busClk);
    compared++;
    if (ifc.busRead !== 1'b1) begin
      mismatched++;
      $display("FAIL midread_strobe: got %b expected 1", ifc.busRead);
    end
    busReset = 1'b1;
    ifc.m0Valid = 1'b0;
    @(negedge busClk);
    busReset = 1'b0;
    compared++;
    if ({ifc.busRead, ifc.m0Grant, ifc.busAddr} !== {1'b0, 1'b0, 18'd0}) begin
      mismatched++;
      $display("FAIL midread_cleared: got rd=%b g0=%b addr=%h expected 0 0 0", ifc.busRead, ifc.m0Grant, ifc.busAddr);
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge busClk);
      compared++;
      if ({ifc.m0RspValid, ifc.m1RspValid} !== 2'b00) begin
        mismatched++;
        $display("FAIL midread_no_rsp_c%0d: got %b expected 00", cyc, {ifc.m0RspValid, ifc.m1RspValid});
      end
    end
    ifc.m0Valid = 1'b1; ifc.m0Write = 1'b1; ifc.m0Addr = 18'h00005; ifc.m0Lock = 1'b0;
    ifc.m1Valid = 1'b1; ifc.m1Write = 1'b1; ifc.m1Addr = 18'h00006; ifc.m1Lock = 1'b0;
    @(negedge busClk);
    compared++;
    if ({ifc.m0Grant, ifc.m1Grant} !== 2'b10) begin
      mismatched++;
      $display("FAIL midread_next_tie: got %b expected 10", {ifc.m0Grant, ifc.m1Grant});
    end
    clearInputs();
  endtask

  initial begin
    busReset = 1'b1;
    clearInputs();
    test_reset();
    test_write_stream();
    test_read_latency();
    test_fairness();
    test_lock_keep();
    test_round_robin();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
